// File: rtl/centroid_pkg.sv
// -----------------------------------------------------------------------------
// centroid_pkg
// Shared definitions for the centroid reporting path:
//   - state_t        : scan state machine encoding (IDLE..DONE)
//   - LOC_W_DEF      : default width of area / coordinate sums and centroids
//   - ID_W_DEF       : default width of object IDs and label counts
//   - centroid_rec_t : one emitted record {id, cx, cy, area}
// -----------------------------------------------------------------------------
`ifndef LOC_SIZE
`define LOC_SIZE 32
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

package centroid_pkg;

    localparam int LOC_W_DEF  = `LOC_SIZE;
    localparam int ID_W_DEF   = `WORD_SIZE;
    localparam int RD_LAT_DEF = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CAPTURE,
        ST_DIVIDE,
        ST_EMIT,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [ID_W_DEF-1:0]  id;
        logic [LOC_W_DEF-1:0] cx;
        logic [LOC_W_DEF-1:0] cy;
        logic [LOC_W_DEF-1:0] area;
    } centroid_rec_t;

endpackage

// File: rtl/centroid_reader_divider.sv
// -----------------------------------------------------------------------------
// serial_divider
// W-bit restoring unsigned divider, one quotient bit per clock.
// A 'go' pulse loads the operands; exactly W cycles later the quotient is
// final and 'ready' pulses for one cycle. Remainder is not exported.
// Ports:
//   clk, reset_n   clock / asynchronous active-low reset
//   go             load dividend/divisor and start
//   dividend       numerator (sampled on go)
//   divisor        denominator (sampled on go, must be non-zero)
//   quotient       floor(dividend / divisor), valid when ready pulses
//   busy           iteration in progress
//   ready          one-cycle pulse when quotient is final
// -----------------------------------------------------------------------------
module serial_divider #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         go,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic         busy,
    output logic         ready
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  rem_reg;
    logic [W-1:0]  quo_reg;
    logic [W-1:0]  dvs_reg;
    logic [CW-1:0] cnt_reg;
    logic          busy_reg;
    logic          ready_reg;

    // Partial remainder shifted left with the next dividend bit; the
    // remainder is always below the divisor so W bits suffice, and bit W
    // of the difference is the "would go negative" flag.
    logic [W:0] shifted;
    logic [W:0] diff;

    assign shifted = {rem_reg, quo_reg[W-1]};
    assign diff    = shifted - {1'b0, dvs_reg};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem_reg   <= '0;
            quo_reg   <= '0;
            dvs_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            ready_reg <= 1'b0;
        end else begin
            ready_reg <= 1'b0;
            if (go) begin
                rem_reg  <= '0;
                quo_reg  <= dividend;
                dvs_reg  <= divisor;
                cnt_reg  <= CW'(W);
                busy_reg <= 1'b1;
            end else if (busy_reg) begin
                // Dividend bits shift out of the top of quo_reg while the
                // quotient bits shift in at the bottom.
                if (!diff[W]) begin
                    rem_reg <= diff[W-1:0];
                end else begin
                    rem_reg <= shifted[W-1:0];
                end
                quo_reg <= {quo_reg[W-2:0], ~diff[W]};
                cnt_reg <= cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) begin
                    busy_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo_reg;
    assign busy     = busy_reg;
    assign ready    = ready_reg;

endmodule

// File: rtl/centroid_reader.sv
// -----------------------------------------------------------------------------
// centroid_reader
// Walks object IDs 1..num_labels through the connected-components data
// table, divides the x/y coordinate sums by the object area and emits one
// centroid record per live (non-zero area) object on a valid/ready stream.
// Ports:
//   clk, reset_n            clock / asynchronous active-low reset
//   start, num_labels       scan request and label count (sampled when idle)
//   obj_id                  table query address
//   obj_area, obj_x, obj_y  table data, valid RD_LAT cycles after obj_id
//   out_valid, out_ready    record handshake
//   out_id/out_cx/out_cy/out_area  record fields
//   busy, done, reported    scan status and count of records accepted
// -----------------------------------------------------------------------------
module centroid_reader
    import centroid_pkg::*;
#(
    parameter int LOC_W  = LOC_W_DEF,
    parameter int ID_W   = ID_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [ID_W-1:0]  num_labels,
    output logic [ID_W-1:0]  obj_id,
    input  logic [LOC_W-1:0] obj_area,
    input  logic [LOC_W-1:0] obj_x,
    input  logic [LOC_W-1:0] obj_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ID_W-1:0]  out_id,
    output logic [LOC_W-1:0] out_cx,
    output logic [LOC_W-1:0] out_cy,
    output logic [LOC_W-1:0] out_area,
    output logic             busy,
    output logic             done,
    output logic [ID_W-1:0]  reported
);

    localparam int CNT_W = 3;

    state_t            state_reg;
    logic [ID_W-1:0]   n_reg;
    logic [ID_W-1:0]   obj_id_reg;
    logic [ID_W-1:0]   reported_reg;
    logic [CNT_W-1:0]  wait_cnt_reg;
    logic [LOC_W-1:0]  area_reg;
    logic              out_valid_reg;
    logic [ID_W-1:0]   out_id_reg;
    logic [LOC_W-1:0]  out_cx_reg;
    logic [LOC_W-1:0]  out_cy_reg;
    logic [LOC_W-1:0]  out_area_reg;
    logic              busy_reg;
    logic              done_reg;

    // Divider lane 0 handles x, lane 1 handles y. Both are launched straight
    // from the table data in CAPTURE so the quotient lands LOC_W cycles later.
    logic              div_go;
    logic              div_done;
    logic [LOC_W-1:0]  div_dividend [2];
    logic [LOC_W-1:0]  div_quotient [2];
    logic              div_busy     [2];
    logic              div_ready    [2];

    assign div_go          = (state_reg == ST_CAPTURE) && (obj_area != '0);
    assign div_dividend[0] = obj_x;
    assign div_dividend[1] = obj_y;
    assign div_done        = div_ready[0] & div_ready[1] & ~div_busy[0] & ~div_busy[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_div
            serial_divider #(
                .W(LOC_W)
            ) u_div (
                .clk      (clk),
                .reset_n  (reset_n),
                .go       (div_go),
                .dividend (div_dividend[gi]),
                .divisor  (obj_area),
                .quotient (div_quotient[gi]),
                .busy     (div_busy[gi]),
                .ready    (div_ready[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            n_reg         <= '0;
            obj_id_reg    <= '0;
            reported_reg  <= '0;
            wait_cnt_reg  <= '0;
            area_reg      <= '0;
            out_valid_reg <= 1'b0;
            out_id_reg    <= '0;
            out_cx_reg    <= '0;
            out_cy_reg    <= '0;
            out_area_reg  <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        n_reg        <= num_labels;
                        reported_reg <= '0;
                        if (num_labels == '0) begin
                            // Empty table: finish straight away.
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                        end else begin
                            busy_reg   <= 1'b1;
                            obj_id_reg <= ID_W'(1);
                            state_reg  <= ST_ISSUE;
                        end
                    end
                end

                ST_ISSUE: begin
                    // ISSUE itself covers the first latency cycle.
                    wait_cnt_reg <= CNT_W'(RD_LAT - 1);
                    state_reg    <= (RD_LAT == 1) ? ST_CAPTURE : ST_WAIT;
                end

                ST_WAIT: begin
                    if (wait_cnt_reg <= CNT_W'(1)) begin
                        state_reg <= ST_CAPTURE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - CNT_W'(1);
                    end
                end

                ST_CAPTURE: begin
                    area_reg <= obj_area;
                    if (obj_area == '0) begin
                        // Label merged away: no record, move on.
                        if (obj_id_reg == n_reg) begin
                            state_reg  <= ST_DONE;
                            done_reg   <= 1'b1;
                            busy_reg   <= 1'b0;
                            obj_id_reg <= '0;
                        end else begin
                            obj_id_reg <= obj_id_reg + ID_W'(1);
                            state_reg  <= ST_ISSUE;
                        end
                    end else begin
                        state_reg <= ST_DIVIDE;
                    end
                end

                ST_DIVIDE: begin
                    if (div_done) begin
                        out_valid_reg <= 1'b1;
                        out_id_reg    <= obj_id_reg;
                        out_cx_reg    <= div_quotient[0];
                        out_cy_reg    <= div_quotient[1];
                        out_area_reg  <= area_reg;
                        state_reg     <= ST_EMIT;
                    end
                end

                ST_EMIT: begin
                    // Fields stay registered and untouched until accepted.
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        reported_reg  <= reported_reg + ID_W'(1);
                        if (obj_id_reg == n_reg) begin
                            state_reg  <= ST_DONE;
                            done_reg   <= 1'b1;
                            busy_reg   <= 1'b0;
                            obj_id_reg <= '0;
                        end else begin
                            obj_id_reg <= obj_id_reg + ID_W'(1);
                            state_reg  <= ST_ISSUE;
                        end
                    end
                end

                ST_DONE: begin
                    // done/busy/obj_id were updated on entry; just return.
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign obj_id    = obj_id_reg;
    assign out_valid = out_valid_reg;
    assign out_id    = out_id_reg;
    assign out_cx    = out_cx_reg;
    assign out_cy    = out_cy_reg;
    assign out_area  = out_area_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign reported  = reported_reg;

endmodule

// File: tb/tb_centroid_reader.sv
// -----------------------------------------------------------------------------
// tb_centroid_reader
// Two centroid_reader instances (RD_LAT=1 and RD_LAT=3) scan the same
// table model. Each lane's table returns correct data only on the exact
// cycle RD_LAT after obj_id changed, garbage otherwise. Expected records are
// computed from the table with plain division when a scan is started.
// -----------------------------------------------------------------------------
module tb_centroid_reader;
    import centroid_pkg::*;

    localparam int LOC_W = LOC_W_DEF;
    localparam int ID_W  = ID_W_DEF;
    localparam int NL    = 2;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic             out_ready = 1'b1;
    logic [ID_W-1:0]  num_labels = '0;

    logic [LOC_W-1:0] tab_area [256];
    logic [LOC_W-1:0] tab_x    [256];
    logic [LOC_W-1:0] tab_y    [256];

    logic             v_a    [NL];
    logic [ID_W-1:0]  oid_a  [NL];
    logic [ID_W-1:0]  id_a   [NL];
    logic [LOC_W-1:0] cx_a   [NL];
    logic [LOC_W-1:0] cy_a   [NL];
    logic [LOC_W-1:0] ar_a   [NL];
    logic             busy_a [NL];
    logic             done_a [NL];
    logic [ID_W-1:0]  rep_a  [NL];

    int tests = 0;
    int fails = 0;
    int scans = 0;
    int rd_idx   [NL];
    int done_cnt [NL];
    logic           stalled [NL];
    logic [127:0]   held    [NL];
    centroid_rec_t  exp_q [$];

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < NL; gi++) begin : g_lane
            localparam int LAT = (gi == 0) ? 1 : 3;
            logic [ID_W-1:0]  oid, rid, rep;
            logic [LOC_W-1:0] area, x, y, cx, cy, rarea;
            logic             valid, bsy, dn;
            logic [ID_W-1:0]  last_id = '0;
            int               age = 0;

            // age = edges since obj_id took its present value
            always @(posedge clk) begin
                last_id <= oid;
                if (oid != last_id) age <= 1;
                else if (age < 1000) age <= age + 1;
            end

            always_comb begin
                area = tab_area[oid];
                x    = tab_x[oid];
                y    = tab_y[oid];
                if (age != LAT) begin
                    area = tab_area[oid] ^ 32'h5A5A_0F0F ^ 32'(age);
                    x    = 32'hDEAD_BEEF;
                    y    = 32'h0BAD_F00D ^ 32'(age);
                end
            end

            centroid_reader #(.LOC_W(LOC_W), .ID_W(ID_W), .RD_LAT(LAT)) dut (
                .clk        (clk),
                .reset_n    (reset_n),
                .start      (start),
                .num_labels (num_labels),
                .obj_id     (oid),
                .obj_area   (area),
                .obj_x      (x),
                .obj_y      (y),
                .out_valid  (valid),
                .out_ready  (out_ready),
                .out_id     (rid),
                .out_cx     (cx),
                .out_cy     (cy),
                .out_area   (rarea),
                .busy       (bsy),
                .done       (dn),
                .reported   (rep)
            );

            assign v_a[gi]    = valid;
            assign oid_a[gi]  = oid;
            assign id_a[gi]   = rid;
            assign cx_a[gi]   = cx;
            assign cy_a[gi]   = cy;
            assign ar_a[gi]   = rarea;
            assign busy_a[gi] = bsy;
            assign done_a[gi] = dn;
            assign rep_a[gi]  = rep;
        end
    endgenerate

    task automatic chk(input string name, input int l, input logic [127:0] got,
                       input logic [127:0] expv);
        tests++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s lane=%0d got=%0h expected=%0h", name, l, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_table();
        for (int i = 0; i < 256; i++) begin
            tab_area[i] = '0;
            tab_x[i]    = '0;
            tab_y[i]    = '0;
        end
    endtask

    task automatic set_obj(input int id, input logic [LOC_W-1:0] a,
                           input logic [LOC_W-1:0] sx, input logic [LOC_W-1:0] sy);
        tab_area[id] = a;
        tab_x[id]    = sx;
        tab_y[id]    = sy;
    endtask

    // Expected records: every live object in ID order, centroid = sum / area.
    task automatic start_scan(input int n);
        centroid_rec_t r;
        exp_q.delete();
        for (int id = 1; id <= n; id++) begin
            if (tab_area[id] != 0) begin
                r.id   = ID_W'(id);
                r.cx   = tab_x[id] / tab_area[id];
                r.cy   = tab_y[id] / tab_area[id];
                r.area = tab_area[id];
                exp_q.push_back(r);
            end
        end
        num_labels = ID_W'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        num_labels = ~ID_W'(n);     // later changes must not matter
        if (n != 0) begin
            for (int l = 0; l < NL; l++) chk("busy_after_start", l, busy_a[l], 1);
        end
    endtask

    task automatic wait_idle();
        int c = 0;
        while ((busy_a[0] || busy_a[1]) && c < 20000) begin
            tick();
            c++;
        end
        chk("scan_timeout", 0, (c < 20000), 1);
        tick();
        scans++;
        for (int l = 0; l < NL; l++) chk("done_pulses", l, done_cnt[l], scans);
    endtask

    task automatic check_reset_vals(input string name);
        for (int l = 0; l < NL; l++)
            chk(name, l, {v_a[l], oid_a[l], id_a[l], cx_a[l], cy_a[l], ar_a[l],
                          busy_a[l], done_a[l], rep_a[l]}, '0);
    endtask

    // Single compare process: every negedge, every lane.
    initial begin
        for (int l = 0; l < NL; l++) begin
            rd_idx[l] = 0; done_cnt[l] = 0; stalled[l] = 1'b0; held[l] = '0;
        end
        forever begin
            @(negedge clk);
            for (int l = 0; l < NL; l++) begin
                if (!reset_n) begin
                    rd_idx[l]  = 0;
                    stalled[l] = 1'b0;
                end else begin
                    if (stalled[l]) begin
                        chk("stall_valid_held", l, v_a[l], 1);
                        chk("stall_fields_held", l,
                            {oid_a[l], id_a[l], cx_a[l], cy_a[l], ar_a[l]}, held[l]);
                    end
                    stalled[l] = 1'b0;
                    if (v_a[l]) begin
                        if (rd_idx[l] >= exp_q.size()) begin
                            tests++;
                            fails++;
                            $display("FAIL unexpected_record lane=%0d got id=%0d expected no record",
                                     l, id_a[l]);
                        end else begin
                            chk("record", l, {id_a[l], cx_a[l], cy_a[l], ar_a[l]},
                                exp_q[rd_idx[l]]);
                            if (out_ready) begin
                                $display("[TB] lane %0d record id=%0d cx=%0d cy=%0d area=%0d",
                                         l, id_a[l], cx_a[l], cy_a[l], ar_a[l]);
                                rd_idx[l]++;
                            end else begin
                                stalled[l] = 1'b1;
                                held[l] = {oid_a[l], id_a[l], cx_a[l], cy_a[l], ar_a[l]};
                            end
                        end
                    end
                    if (done_a[l]) begin
                        chk("done_reported", l, rep_a[l], exp_q.size());
                        chk("done_all_records", l, rd_idx[l], exp_q.size());
                        chk("done_busy_low", l, busy_a[l], 0);
                        chk("done_obj_id_zero", l, oid_a[l], 0);
                        $display("[TB] lane %0d scan done reported=%0d", l, rep_a[l]);
                        rd_idx[l] = 0;
                        done_cnt[l]++;
                    end
                end
            end
        end
    end

    initial begin
        int lat [NL];
        int c;
        logic seen [NL];
        clear_table();
        #1;
        check_reset_vals("reset_values");
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // Empty table
        start_scan(0);
        for (int l = 0; l < NL; l++) seen[l] = done_a[l];
        tick();
        for (int l = 0; l < NL; l++) chk("n0_done_within_2", l, seen[l] | done_a[l], 1);
        wait_idle();
        for (int l = 0; l < NL; l++) chk("n0_reported", l, rep_a[l], 0);

        // Single object, latency check
        clear_table();
        set_obj(1, 4, 40, 12);
        start_scan(1);
        chk("model_n1", 0, {exp_q.size(), exp_q[0]},
            {32'd1, ID_W'(1), 32'd10, 32'd3, 32'd4});
        for (int l = 0; l < NL; l++) lat[l] = -1;
        c = 0;
        while ((lat[0] < 0 || lat[1] < 0) && c < 200) begin
            for (int l = 0; l < NL; l++) if (v_a[l] && lat[l] < 0) lat[l] = c;
            tick();
            c++;
        end
        chk("latency_rdlat1", 0, lat[0], 3 + LOC_W);
        chk("latency_rdlat3", 1, lat[1], 5 + LOC_W);
        wait_idle();
        for (int l = 0; l < NL; l++) chk("n1_reported", l, rep_a[l], 1);

        // Three labels, the middle one merged away; start while busy ignored
        clear_table();
        set_obj(1, 5, 11, 0);
        set_obj(2, 0, 9, 0);
        set_obj(3, 2, 7, 3);
        start_scan(3);
        chk("model_n3", 0, {exp_q.size(), exp_q[0], exp_q[1]},
            {32'd2, ID_W'(1), 32'd2, 32'd0, 32'd5, ID_W'(3), 32'd3, 32'd1, 32'd2});
        repeat (5) tick();
        num_labels = ID_W'(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle();
        for (int l = 0; l < NL; l++) chk("n3_reported", l, rep_a[l], 2);

        // Back-pressure: out_ready low for 20 cycles with a record pending
        clear_table();
        set_obj(1, 3, 10, 7);
        out_ready = 1'b0;
        start_scan(1);
        c = 0;
        while (!(v_a[0] && v_a[1]) && c < 200) begin
            tick();
            c++;
        end
        chk("stall_reached_emit", 0, (c < 200), 1);
        repeat (20) tick();
        out_ready = 1'b1;
        wait_idle();
        for (int l = 0; l < NL; l++) chk("stall_reported", l, rep_a[l], 1);

        // Wide operands and a unit divisor
        clear_table();
        set_obj(1, 7, 32'hFFFF_FFFF, 12345);
        set_obj(2, 1, 5, 9);
        start_scan(2);
        chk("model_wide", 0, exp_q[0].cx, 32'd613566756);
        wait_idle();

        // Reset in the middle of DIVIDE, then a fresh scan
        clear_table();
        set_obj(1, 6, 60, 30);
        set_obj(2, 2, 3, 5);
        start_scan(2);
        repeat (10) tick();
        reset_n = 1'b0;
        #1;
        check_reset_vals("reset_mid_divide");
        exp_q.delete();
        tick(); tick();
        check_reset_vals("reset_held");
        reset_n = 1'b1;
        tick();
        clear_table();
        set_obj(1, 9, 100, 27);
        set_obj(2, 0, 0, 0);
        set_obj(3, 4, 6, 17);
        start_scan(3);
        wait_idle();
        for (int l = 0; l < NL; l++) chk("after_reset_reported", l, rep_a[l], 2);

        // Full label range: no wrap after ID 255
        clear_table();
        set_obj(254, 2, 9, 4);
        set_obj(255, 255, 255 * 200, 255 * 3);
        start_scan(255);
        wait_idle();
        for (int l = 0; l < NL; l++) begin
            chk("n255_reported", l, rep_a[l], 2);
            chk("n255_obj_id", l, oid_a[l], 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
